// File: rtl/epu_input_fetch.sv
// epu_input_fetch: streaming 2-D tile reader for the EPU side of the input buffer.
// Walks rows x cols words (row starts separated by row_stride) out of a
// single-port SRAM with 1-cycle read latency and delivers them on a valid/ready
// stream through a small credit-controlled FIFO.
// Optional build macro EPU_FETCH_ZPAD_EN adds pad_i: every row is framed by
// pad_i zero words on each side. The zero words take a FIFO credit but no SRAM access.
`timescale 1ns/1ps

module epu_input_fetch #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int DIM_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [DIM_W-1:0]  cols_i,
  input  logic [DIM_W-1:0]  rows_i,
  input  logic [ADDR_W-1:0] row_stride_i,
`ifdef EPU_FETCH_ZPAD_EN
  input  logic [1:0]        pad_i,
`endif
  output logic              sram_cs_o,
  output logic              sram_oe_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_wreq_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              row_last_o,
  output logic              tile_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = DIM_W + 2;   // row length can include up to 2*3 pad words
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
  localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             WRITE_DIS = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  logic [DIM_W-1:0]    cols_r, rows_r, row_r;
  logic [ADDR_W-1:0]   stride_r, row_ptr_r;
  logic [COL_W-1:0]    col_r;
`ifdef EPU_FETCH_ZPAD_EN
  logic [1:0]          pad_r;
`endif
  logic                busy_r, done_r;
  logic                inflight_r, infl_pad_r, infl_rl_r, infl_tl_r;
  logic [DATA_W-1:0]   mem_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_rl_r, mem_tl_r;
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r;

  logic [COL_W-1:0]    pad_s, cols_ext_s, row_len_s;
  logic                is_pad_s, row_last_s, tile_last_s, issue_s, rd_s;
  logic [CNT_W:0]      occ_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                valid_s, push_s, pop_s;
  logic [DATA_W-1:0]   push_data_s;

  // Walk position decode and credit: issue only from registered occupancy, never from ready_i.
  always_comb begin
    pad_s = {COL_W{1'b0}};
`ifdef EPU_FETCH_ZPAD_EN
    pad_s = {{(COL_W-2){1'b0}}, pad_r};
`endif
    cols_ext_s  = {2'b00, cols_r};
    row_len_s   = cols_ext_s + pad_s + pad_s;
    is_pad_s    = (col_r < pad_s) || (col_r >= (pad_s + cols_ext_s));
    row_last_s  = (col_r == (row_len_s - COL_ONE));
    tile_last_s = row_last_s && (row_r == (rows_r - DIM_ONE));
    occ_s       = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    issue_s     = (state_r == ST_FETCH) && (occ_s < DEPTH_C);
    rd_s        = issue_s && !is_pad_s;
    addr_s      = row_ptr_r + ADDR_W'(col_r - pad_s);
    valid_s     = (count_r != {CNT_W{1'b0}});
    pop_s       = valid_s && ready_i;
    push_s      = inflight_r;
  end

  // Capture mux: pad slots push zero instead of the SRAM read data.
  always_comb begin
    if (infl_pad_r) begin
      push_data_s = {DATA_W{1'b0}};
    end else begin
      push_data_s = sram_rdata_i;
    end
  end

  // SRAM port and stream outputs; head data is masked while the FIFO is empty.
  always_comb begin
    sram_cs_o   = rd_s;
    sram_oe_o   = rd_s;
    sram_wreq_o = WRITE_DIS;
    if (rd_s) begin
      sram_addr_o = addr_s;
    end else begin
      sram_addr_o = {ADDR_W{1'b0}};
    end
    valid_o = valid_s;
    if (valid_s) begin
      data_o      = mem_data_r[rd_ptr_r];
      row_last_o  = mem_rl_r[rd_ptr_r];
      tile_last_o = mem_tl_r[rd_ptr_r];
    end else begin
      data_o      = {DATA_W{1'b0}};
      row_last_o  = 1'b0;
      tile_last_o = 1'b0;
    end
    busy_o = busy_r;
    done_o = done_r;
  end

  // Main FSM: latches the job, walks col/row/row_ptr per issue, registers busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cols_r    <= {DIM_W{1'b0}};
      rows_r    <= {DIM_W{1'b0}};
      row_r     <= {DIM_W{1'b0}};
      col_r     <= {COL_W{1'b0}};
      stride_r  <= {ADDR_W{1'b0}};
      row_ptr_r <= {ADDR_W{1'b0}};
`ifdef EPU_FETCH_ZPAD_EN
      pad_r     <= 2'b00;
`endif
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            cols_r    <= cols_i;
            rows_r    <= rows_i;
            stride_r  <= row_stride_i;
            row_ptr_r <= base_addr_i;
            col_r     <= {COL_W{1'b0}};
            row_r     <= {DIM_W{1'b0}};
`ifdef EPU_FETCH_ZPAD_EN
            pad_r     <= pad_i;
`endif
            busy_r    <= 1'b1;
            if ((cols_i == {DIM_W{1'b0}}) || (rows_i == {DIM_W{1'b0}})) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_FETCH;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (issue_s) begin
            if (row_last_s) begin
              col_r     <= {COL_W{1'b0}};
              row_r     <= row_r + DIM_ONE;
              row_ptr_r <= row_ptr_r + stride_r;
            end else begin
              col_r <= col_r + COL_ONE;
            end
            if (tile_last_s) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_FETCH;
            end
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (!valid_s && !inflight_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency stage: remembers that a slot was issued and the flags computed at issue time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= 1'b0;
      infl_pad_r <= 1'b0;
      infl_rl_r  <= 1'b0;
      infl_tl_r  <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      infl_pad_r <= issue_s && is_pad_s;
      infl_rl_r  <= row_last_s;
      infl_tl_r  <= tile_last_s;
    end
  end

  // FIFO storage; contents need no reset because the outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= push_data_s;
      mem_rl_r[wr_ptr_r]   <= infl_rl_r;
      mem_tl_r[wr_ptr_r]   <= infl_tl_r;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_epu_input_fetch.sv
// Self-checking bench for epu_input_fetch: SRAM model, scoreboard queues for
// expected addresses and stream words, directed tile scenarios.
`timescale 1ns/1ps

module tb_epu_input_fetch;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        rl;
    logic        tl;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] base_addr = 18'h0;
  logic [17:0] row_stride = 18'h0;
  logic [9:0]  cols = 10'h0;
  logic [9:0]  rows = 10'h0;
`ifdef EPU_FETCH_ZPAD_EN
  logic [1:0]  pad = 2'b00;
`endif
  logic        sram_cs, sram_oe, sram_wreq;
  logic [17:0] sram_addr;
  logic [31:0] sram_rdata = 32'h0;
  logic [31:0] data;
  logic        valid, row_last, tile_last, busy, done;
  logic        ready = 1'b0;

  word_t       exp_q[$];
  logic [17:0] addr_q[$];
  int n_cmp = 0, n_err = 0;
  int rd_issued = 0, words_xfer = 0, out_base = 0, done_cnt = 0;
  bit zmode = 1'b0;

  epu_input_fetch dut (
    .clk          (clk),
    .rst          (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .cols_i       (cols),
    .rows_i       (rows),
    .row_stride_i (row_stride),
`ifdef EPU_FETCH_ZPAD_EN
    .pad_i        (pad),
`endif
    .sram_cs_o    (sram_cs),
    .sram_oe_o    (sram_oe),
    .sram_addr_o  (sram_addr),
    .sram_wreq_o  (sram_wreq),
    .sram_rdata_i (sram_rdata),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .row_last_o   (row_last),
    .tile_last_o  (tile_last),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    if (zmode) mem_word = 32'h0000_000A + {14'h0, a};
    else       mem_word = 32'hC0DE_0000 ^ {14'h0, a};
  endfunction

  // SRAM model: data appears the cycle after cs&oe.
  always @(posedge clk) begin
    if (sram_cs && sram_oe) sram_rdata <= mem_word(sram_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor_step();
    word_t w;
    if (sram_cs) begin
      check("credit", 64'((rd_issued - words_xfer - out_base) < DEPTH), 64'd1);
      check("wreq", sram_wreq, 1'b0);
      if (addr_q.size() == 0) check("cs_unexp", sram_cs, 1'b0);
      else                    check("addr", sram_addr, addr_q.pop_front());
      rd_issued++;
    end
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("valid_unexp", valid, 1'b0);
      end else begin
        w = exp_q[0];
        check("data", data, w.d);
        check("row_last", row_last, w.rl);
        check("tile_last", tile_last, w.tl);
        if (ready) begin
          void'(exp_q.pop_front());
          words_xfer++;
        end
      end
    end
    if (done) done_cnt++;
  endtask

  // Reference walk: push expected SRAM addresses and stream words.
  task automatic push_expect(input logic [17:0] b, input logic [9:0] c, input logic [9:0] r,
                             input logic [17:0] s, input logic [1:0] p);
    logic [17:0] ptr, a;
    word_t w;
    int len;
    if (c == 10'd0 || r == 10'd0) return;
    ptr = b;
    len = int'(c) + 2 * int'(p);
    for (int ri = 0; ri < int'(r); ri++) begin
      for (int ci = 0; ci < len; ci++) begin
        w.rl = (ci == len - 1);
        w.tl = w.rl && (ri == int'(r) - 1);
        if (ci < int'(p) || ci >= int'(p) + int'(c)) begin
          w.d = 32'h0;
        end else begin
          a = ptr + 18'(ci - int'(p));
          addr_q.push_back(a);
          w.d = mem_word(a);
        end
        exp_q.push_back(w);
      end
      ptr = ptr + s;
    end
  endtask

  task automatic drive_start(input logic [17:0] b, input logic [9:0] c, input logic [9:0] r,
                             input logic [17:0] s, input logic [1:0] p);
    @(posedge clk); #1;
    base_addr = b; cols = c; rows = r; row_stride = s; start = 1'b1; ready = 1'b1;
`ifdef EPU_FETCH_ZPAD_EN
    pad = p;
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_tile(input logic [17:0] b, input logic [9:0] c, input logic [9:0] r,
                          input logic [17:0] s, input logic [1:0] p, input int st_lo, input int st_hi);
    int d0, k, first_v;
    bit zero_tile;
    zero_tile = (c == 10'd0) || (r == 10'd0);
    push_expect(b, c, r, s, p);
    d0 = done_cnt;
    first_v = -1;
    drive_start(b, c, r, s, p);
    k = 0;
    check("busy_start", busy, 1'b1);
    if (zero_tile) check("zero_done", done, 1'b1);
    ready = !(k >= st_lo && k <= st_hi);
    while (done_cnt == d0 && k < 300) begin
      @(posedge clk); #1;
      k++;
      ready = !(k >= st_lo && k <= st_hi);
      if (valid && first_v < 0) first_v = k;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
    if (!zero_tile) check("first_valid_lat", 64'(first_v), 64'd2);
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("words_left", 64'(exp_q.size()), 64'd0);
    check("addr_left", 64'(addr_q.size()), 64'd0);
    check("busy_end", busy, 1'b0);
  endtask

  initial begin
    int w0, k;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", sram_cs, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic tile, then the same tile under back-pressure
    run_tile(18'h00100, 10'd4, 10'd2, 18'h8, 2'd0, -1, -1);
    run_tile(18'h00100, 10'd4, 10'd2, 18'h8, 2'd0, 3, 10);
    // address wrap
    run_tile(18'h3FFFE, 10'd4, 10'd1, 18'h8, 2'd0, -1, -1);
    // degenerate tile
    run_tile(18'h00040, 10'd0, 10'd5, 18'h1, 2'd0, -1, -1);

    // reset in the middle of a tile after three transferred words
    push_expect(18'h00200, 10'd4, 10'd2, 18'h10, 2'd0);
    w0 = words_xfer;
    drive_start(18'h00200, 10'd4, 10'd2, 18'h10, 2'd0);
    k = 0;
    while ((words_xfer - w0) < 3 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_words", 64'(words_xfer - w0), 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_cs", sram_cs, 1'b0);
    check("mid_valid", valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_data", data, 32'h0);
    check("mid_flags", {row_last, tile_last, done}, 3'b000);
    exp_q.delete();
    addr_q.delete();
    out_base = rd_issued - words_xfer;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(18'h00300, 10'd2, 10'd1, 18'h4, 2'd0, -1, -1);

`ifdef EPU_FETCH_ZPAD_EN
    zmode = 1'b1;
    w0 = rd_issued;
    run_tile(18'h00000, 10'd2, 10'd1, 18'h0, 2'd1, -1, -1);
    check("zpad_reads", 64'(rd_issued - w0), 64'd2);
    zmode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
